// File: rtl/neuron_param_loader.sv
// Streams config words into the neuron array as one registered write strobe per accepted word (1-cycle latency).
// Intake stalls on hold_i/abort_i via cfg_ready_o; NEURON_PARAM_LOADER_CHECKSUM_EN adds an XOR-checked trailer word.
module neuron_param_loader #(
  parameter int NUM_NEURONS      = 32,
  parameter int WORDS_PER_NEURON = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        hold_i,
  input  logic        cfg_valid_i,
  input  logic [31:0] cfg_data_i,
  output logic        cfg_ready_o,
  output logic        param_select_o,
  output logic [4:0]  param_num_o,
  output logic        we_o,
  output logic [1:0]  addr_o,
  output logic [31:0] d_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        chk_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [1:0] LAST_ADDR   = 2'(WORDS_PER_NEURON - 1);
  localparam logic [4:0] LAST_NEURON = 5'(NUM_NEURONS - 1);

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  addr_cnt;
  logic [4:0]  neuron_cnt;
  logic        sel_q;
  logic [4:0]  num_q;
  logic [1:0]  waddr_q;
  logic [31:0] data_q;

  logic intake;
  logic ready;
  logic accept;
  logic load_accept;
  logic last_word;
  logic start_go;
  logic abort_go;

  assign intake      = (state_q == LOAD) || (state_q == CHECK);
  assign ready       = intake && !hold_i && !abort_i;
  assign accept      = ready && cfg_valid_i;
  assign load_accept = accept && (state_q == LOAD);
  assign last_word   = (addr_cnt == LAST_ADDR) && (neuron_cnt == LAST_NEURON);
  assign start_go    = (state_q == IDLE) && start_i && !abort_i;
  assign abort_go    = intake && abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_go) state_d = LOAD;
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (load_accept && last_word) begin
`ifdef NEURON_PARAM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = FIN;
`endif
        end
      end
      CHECK: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An abort masks the strobe already sitting in the output register.
  always_comb begin
    cfg_ready_o    = ready;
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == FIN);
    param_select_o = sel_q && !abort_go;
    we_o           = sel_q && !abort_go;
    param_num_o    = num_q;
    addr_o         = waddr_q;
    d_o            = data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_cnt   <= 2'd0;
      neuron_cnt <= 5'd0;
    end else if (start_go || abort_go) begin
      addr_cnt   <= 2'd0;
      neuron_cnt <= 5'd0;
    end else if (load_accept) begin
      if (addr_cnt == LAST_ADDR) begin
        addr_cnt   <= 2'd0;
        neuron_cnt <= neuron_cnt + 5'd1;
      end else begin
        addr_cnt <= addr_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q   <= 1'b0;
      num_q   <= 5'd0;
      waddr_q <= 2'd0;
      data_q  <= 32'd0;
    end else begin
      sel_q <= load_accept;
      if (load_accept) begin
        num_q   <= neuron_cnt;
        waddr_q <= addr_cnt;
        data_q  <= cfg_data_i;
      end
    end
  end

`ifdef NEURON_PARAM_LOADER_CHECKSUM_EN
  logic [31:0] acc_q;
  logic        chk_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= 32'd0;
      chk_err_q <= 1'b0;
    end else if (start_go) begin
      acc_q     <= 32'd0;
      chk_err_q <= 1'b0;
    end else if (load_accept) begin
      acc_q <= acc_q ^ cfg_data_i;
    end else if (accept && (state_q == CHECK)) begin
      chk_err_q <= (cfg_data_i != acc_q);
    end
  end

  assign chk_err_o = chk_err_q;
`else
  assign chk_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_param_loader.sv
// Bench for neuron_param_loader: scoreboard of expected strobes, ready truth table, abort/reset/stall/override sequences.
module tb_neuron_param_loader;

  localparam int N     = 32;
  localparam int W     = 4;
  localparam int TOTAL = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort, hold, valid;
  logic [31:0] cfg_data;
  logic        cfg_ready, param_select, we, busy, done, chk_err;
  logic [4:0]  param_num;
  logic [1:0]  addr;
  logic [31:0] d;

  neuron_param_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .hold_i(hold),
    .cfg_valid_i(valid), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready),
    .param_select_o(param_select), .param_num_o(param_num), .we_o(we), .addr_o(addr),
    .d_o(d), .busy_o(busy), .done_o(done), .chk_err_o(chk_err)
  );

  logic        b_start, b_abort, b_hold, b_valid;
  logic [31:0] b_data;
  logic        b_ready, b_sel, b_we, b_busy, b_done, b_chk_err;
  logic [4:0]  b_num;
  logic [1:0]  b_addr;
  logic [31:0] b_d;

  neuron_param_loader #(.NUM_NEURONS(3), .WORDS_PER_NEURON(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .abort_i(b_abort), .hold_i(b_hold),
    .cfg_valid_i(b_valid), .cfg_data_i(b_data), .cfg_ready_o(b_ready),
    .param_select_o(b_sel), .param_num_o(b_num), .we_o(b_we), .addr_o(b_addr),
    .d_o(b_d), .busy_o(b_busy), .done_o(b_done), .chk_err_o(b_chk_err)
  );

  typedef struct packed {
    logic [4:0]  num;
    logic [1:0]  addr;
    logic [31:0] d;
  } strobe_t;

  typedef struct {
    logic in_load;
    logic h;
    logic a;
    logic v;
    logic exp_rdy;
  } vec_t;

  strobe_t exp_q[$];
  strobe_t b_seen[$];
  vec_t    vecs[16];

  int checks = 0;
  int passed = 0;
  int nxt = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int b_done_cnt = 0;
  int b_done_on_last = 0;
  logic acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (param_select) begin
        strobe_t e;
        strobe_cnt++;
        check("we_eq_select", 32'(we), 32'(1));
        check("strobe_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("strobe_num", 32'(param_num), 32'(e.num));
          check("strobe_addr", 32'(addr), 32'(e.addr));
          check("strobe_data", d, e.d);
        end
      end
      if (done) done_cnt++;
      if (b_sel) b_seen.push_back('{num: b_num, addr: b_addr, d: b_d});
      if (b_done) begin
        b_done_cnt++;
        if (b_sel && b_d == 32'd5) b_done_on_last++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; an accepted word is pushed to the scoreboard at the edge.
  task automatic step(input logic v, input logic h, input logic a);
    strobe_t e;
    valid = v; hold = h; abort = a; cfg_data = 32'(nxt);
    @(negedge clk);
    acc = v && cfg_ready;
    @(posedge clk);
    if (acc) begin
      e = '{num: 5'(nxt / W), addr: 2'(nxt % W), d: 32'(nxt)};
      exp_q.push_back(e);
      nxt++;
    end
    #1;
    valid = 1'b0; hold = 1'b0; abort = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    nxt = 0;
    strobe_cnt = 0;
  endtask

  task automatic run_load(input bit stall, input logic [31:0] trailer, input logic exp_err);
    int guard = 0;
    int d0;
    bit s1 = 0;
    bit s2 = 0;
    do_start();
    d0 = done_cnt;
    while (nxt < TOTAL && guard < 2000) begin
      guard++;
      if (stall && nxt == 20 && !s1) begin
        s1 = 1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
      end else if (stall && nxt == 50 && !s2) begin
        s2 = 1;
        repeat (5) step(1'b1, 1'b1, 1'b0);
      end else begin
        step(1'b1, 1'b0, 1'b0);
      end
    end
    check("all_words_accepted", 32'(nxt), 32'(TOTAL));
`ifdef NEURON_PARAM_LOADER_CHECKSUM_EN
    valid = 1'b1; cfg_data = trailer;
    @(negedge clk);
    check("trailer_ready", 32'(cfg_ready), 32'(1));
    tick();
    valid = 1'b0;
    @(negedge clk);
    check("done_fin", 32'(done), 32'(1));
    check("no_strobe_for_trailer", 32'(param_select), 32'(0));
    check("chk_err", 32'(chk_err), 32'(exp_err));
`else
    @(negedge clk);
    check("done_fin", 32'(done), 32'(1));
    check("done_with_last_strobe", 32'(param_select), 32'(1));
    check("last_strobe_data", d, 32'(TOTAL - 1));
    check("busy_in_fin", 32'(busy), 32'(1));
    check("chk_err_tied", 32'(chk_err), 32'(exp_err & 1'b0));
    if (trailer != 32'd0) $display("note: trailer unused in this build");
`endif
    tick();
    @(negedge clk);
    check("busy_after_fin", 32'(busy), 32'(0));
    check("done_single", 32'(done), 32'(0));
    #1;
    check("strobe_count", 32'(strobe_cnt), 32'(TOTAL));
    check("done_count", 32'(done_cnt - d0), 32'(1));
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int d0;
    int exp_n[6] = '{0, 0, 1, 1, 2, 2};
    int exp_a[6] = '{0, 1, 0, 1, 0, 1};

    for (int i = 0; i < 16; i++) begin
      vecs[i].in_load = (i >= 8);
      vecs[i].h       = i[2];
      vecs[i].a       = i[1];
      vecs[i].v       = i[0];
      vecs[i].exp_rdy = (i >= 8) && !i[2] && !i[1];
    end

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; valid = 1'b0; cfg_data = 32'd0;
    b_start = 1'b0; b_abort = 1'b0; b_hold = 1'b0; b_valid = 1'b0; b_data = 32'd0;
    #12;
    check("rst_ready", 32'(cfg_ready), 32'(0));
    check("rst_select", 32'(param_select), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_chk_err", 32'(chk_err), 32'(0));
    check("rst_num_addr", {25'd0, param_num, addr}, 32'd0);
    check("rst_data", d, 32'd0);
    rst_n = 1'b1;
    tick();

    // cfg_ready truth table, applied and withdrawn between edges.
    for (int i = 0; i < 16; i++) begin
      if (i == 8) do_start();
      hold = vecs[i].h; abort = vecs[i].a; valid = vecs[i].v;
      #2;
      check($sformatf("ready_vec%0d", i), 32'(cfg_ready), 32'(vecs[i].exp_rdy));
      hold = 1'b0; abort = 1'b0; valid = 1'b0;
      tick();
    end
    step(1'b0, 1'b0, 1'b1);
    check("abort_idle_from_table", 32'(busy), 32'(0));

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 32'(busy), 32'(0));
    tick();

    run_load(1'b0, 32'h0, 1'b0);

    // Abort while word 37's strobe is pending and word 38 is offered.
    do_start();
    d0 = done_cnt;
    guard = 0;
    while (nxt < 38 && guard < 200) begin
      guard++;
      step(1'b1, 1'b0, 1'b0);
    end
    void'(exp_q.pop_back());
    valid = 1'b1; cfg_data = 32'd38; abort = 1'b1;
    #1;
    check("abort_ready_low", 32'(cfg_ready), 32'(0));
    check("abort_cancels_strobe", 32'(param_select), 32'(0));
    tick();
    valid = 1'b0; abort = 1'b0;
    check("abort_to_idle", 32'(busy), 32'(0));
    @(negedge clk);
    check("abort_no_late_strobe", 32'(param_select), 32'(0));
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'(0));
    check("abort_strobes", 32'(strobe_cnt), 32'(37));
    check("abort_scoreboard", 32'(exp_q.size()), 32'(0));
    tick();

    // Fresh start, then asynchronous reset after ten accepts.
    do_start();
    guard = 0;
    while (nxt < 10 && guard < 200) begin
      guard++;
      step(1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("arst_select", 32'(param_select), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_ready", 32'(cfg_ready), 32'(0));
    check("arst_num_addr", {25'd0, param_num, addr}, 32'd0);
    check("arst_data", d, 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'(0));
    tick();

    run_load(1'b1, 32'h0, 1'b0);

`ifdef NEURON_PARAM_LOADER_CHECKSUM_EN
    run_load(1'b0, 32'h1, 1'b1);
    repeat (3) tick();
    check("chk_err_held", 32'(chk_err), 32'(1));
    do_start();
    check("chk_err_cleared_on_start", 32'(chk_err), 32'(0));
    step(1'b0, 1'b0, 1'b1);
`endif

    // Small array: 3 neurons x 2 words.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_valid = 1'b1; b_data = 32'(i);
      tick();
    end
    b_valid = 1'b0;
`ifdef NEURON_PARAM_LOADER_CHECKSUM_EN
    b_valid = 1'b1; b_data = 32'h1;
    tick();
    b_valid = 1'b0;
`endif
    repeat (3) tick();
    check("small_strobe_count", 32'(b_seen.size()), 32'(6));
    for (int i = 0; i < 6 && i < b_seen.size(); i++) begin
      check($sformatf("small_num%0d", i), 32'(b_seen[i].num), 32'(exp_n[i]));
      check($sformatf("small_addr%0d", i), 32'(b_seen[i].addr), 32'(exp_a[i]));
      check($sformatf("small_data%0d", i), b_seen[i].d, 32'(i));
    end
    check("small_done", 32'(b_done_cnt), 32'(1));
`ifndef NEURON_PARAM_LOADER_CHECKSUM_EN
    check("small_done_on_last", 32'(b_done_on_last), 32'(1));
`endif
    check("small_idle", 32'(b_busy), 32'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
